mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 105 ++++++++++
 tb/tb_mem_io_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: RAM, UART TX/RX FIFOs and a status/halt register.
// Every rdy_in-qualified rising edge is a transaction; read data lands on mem_din one cycle later.
module mem_io_responder #(
   parameter int RAM_AW  = 17,
   parameter int FIFO_AW = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        uart_tx_valid,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_ready,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_data,
   output logic        sim_halt
);
   localparam int DEPTH = 2 ** FIFO_AW;
   typedef logic [FIFO_AW:0]   cnt_t;
   typedef logic [FIFO_AW-1:0] ptr_t;
   localparam cnt_t LP_DEPTH  = cnt_t'(DEPTH);
   localparam cnt_t LP_THRESH = cnt_t'(DEPTH - 2);

   logic [7:0] r_ram    [2**RAM_AW];
   logic [7:0] r_tx_mem [DEPTH];
   logic [7:0] r_rx_mem [DEPTH];
   ptr_t       r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   cnt_t       r_tx_cnt, r_rx_cnt;
   logic       r_tx_ovf, r_rx_ovr;

   logic       w_is_io, w_uart_sel, w_stat_sel, w_wr, w_rd;
   logic       w_tx_full, w_rx_full, w_rx_ne;
   logic       w_tx_push, w_tx_pop, w_tx_drop, w_rx_push, w_rx_pop, w_rx_drop;
   cnt_t       w_tx_cnt_nxt;
   logic [7:0] w_rd_data;
   logic       w_unused_ok;

   assign w_is_io     = (mem_a[17:16] == 2'b11);
   assign w_uart_sel  = w_is_io && (mem_a[15:0] == 16'h0000);
   assign w_stat_sel  = w_is_io && (mem_a[15:0] == 16'h0004);
   assign w_wr        = rdy_in && mem_wr;
   assign w_rd        = rdy_in && !mem_wr;
   assign w_unused_ok = &{1'b0, mem_a[31:18]};

   assign w_tx_full     = (r_tx_cnt == LP_DEPTH);
   assign w_rx_full     = (r_rx_cnt == LP_DEPTH);
   assign w_rx_ne       = (r_rx_cnt != '0);
   assign uart_tx_valid = (r_tx_cnt != '0);
   assign uart_tx_data  = r_tx_mem[r_tx_rp];

   // A pop in the same cycle frees a slot, so a push at full is still accepted.
   assign w_tx_pop     = uart_tx_valid && uart_tx_ready;
   assign w_tx_push    = w_wr && w_uart_sel && (!w_tx_full || w_tx_pop);
   assign w_tx_drop    = w_wr && w_uart_sel && w_tx_full && !w_tx_pop;
   assign w_rx_pop     = w_rd && w_uart_sel && w_rx_ne;
   assign w_rx_push    = uart_rx_valid && (!w_rx_full || w_rx_pop);
   assign w_rx_drop    = uart_rx_valid && w_rx_full && !w_rx_pop;
   assign w_tx_cnt_nxt = r_tx_cnt + cnt_t'(w_tx_push) - cnt_t'(w_tx_pop);

   always_comb begin
      w_rd_data = 8'h00;
      if (!w_is_io)        w_rd_data = r_ram[mem_a[RAM_AW-1:0]];
      else if (w_uart_sel) w_rd_data = w_rx_ne ? r_rx_mem[r_rx_rp] : 8'h00;
      else if (w_stat_sel) w_rd_data = {5'b0, r_tx_ovf, r_rx_ovr, w_rx_ne};
   end

   // Storage arrays carry no reset; RAM contents survive rst_in.
   always_ff @(posedge clk_in) begin
      if (w_wr && !w_is_io) r_ram[mem_a[RAM_AW-1:0]] <= mem_dout;
      if (w_tx_push)        r_tx_mem[r_tx_wp]        <= mem_dout;
      if (w_rx_push)        r_rx_mem[r_rx_wp]        <= uart_rx_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mem_din        <= 8'h00;
         io_buffer_full <= 1'b0;
         sim_halt       <= 1'b0;
         r_tx_ovf       <= 1'b0;
         r_rx_ovr       <= 1'b0;
         r_tx_wp        <= '0;
         r_tx_rp        <= '0;
         r_rx_wp        <= '0;
         r_rx_rp        <= '0;
         r_tx_cnt       <= '0;
         r_rx_cnt       <= '0;
      end else begin
         if (w_rd)                mem_din  <= w_rd_data;
         if (w_wr && w_stat_sel)  sim_halt <= 1'b1;
         if (w_tx_drop)           r_tx_ovf <= 1'b1;
         if (w_rx_drop)           r_rx_ovr <= 1'b1;
         if (w_tx_push)           r_tx_wp  <= r_tx_wp + ptr_t'(1);
         if (w_tx_pop)            r_tx_rp  <= r_tx_rp + ptr_t'(1);
         if (w_rx_push)           r_rx_wp  <= r_rx_wp + ptr_t'(1);
         if (w_rx_pop)            r_rx_rp  <= r_rx_rp + ptr_t'(1);
         r_tx_cnt       <= w_tx_cnt_nxt;
         r_rx_cnt       <= r_rx_cnt + cnt_t'(w_rx_push) - cnt_t'(w_rx_pop);
         io_buffer_full <= (w_tx_cnt_nxt >= LP_THRESH);
      end
   end
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: vector table, directed corner sequences and random traffic
// checked against a queue/array reference model.
module tb_mem_io_responder;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, mem_wr, uart_tx_ready, uart_rx_valid;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout, uart_rx_data, mem_din, uart_tx_data;
   logic        io_buffer_full, uart_tx_valid, sim_halt;

   always #5 clk_in = ~clk_in;

   mem_io_responder #(.RAM_AW(17), .FIFO_AW(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .io_buffer_full(io_buffer_full), .uart_tx_valid(uart_tx_valid),
      .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
      .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .sim_halt(sim_halt)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] m_ram [int];
   logic [7:0] m_tx [$];
   logic [7:0] m_rx [$];
   logic [7:0] m_din;
   bit         din_ok, m_txo, m_rxo, m_halt;

   typedef struct {
      bit          rdy;
      bit          wr;
      logic [31:0] a;
      logic [7:0]  d;
      logic [7:0]  exp;
   } vec_t;
   vec_t tbl [16];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances from the rules, then all outputs are compared.
   task automatic cyc(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] d,
                      input bit txr, input bit rxv, input logic [7:0] rxd);
      int ra;
      bit io;
      rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d;
      uart_tx_ready = txr; uart_rx_valid = rxv; uart_rx_data = rxd;
      io = (a[17:16] == 2'b11);
      ra = int'(a & 32'h0001FFFF);
      if (txr && m_tx.size() != 0) void'(m_tx.pop_front());
      if (rdy && !wr) begin
         din_ok = 1'b1;
         if (!io) begin
            if (m_ram.exists(ra)) m_din = m_ram[ra];
            else din_ok = 1'b0;
         end else if (a[15:0] == 16'h0000) begin
            m_din = (m_rx.size() != 0) ? m_rx.pop_front() : 8'h00;
         end else if (a[15:0] == 16'h0004) begin
            m_din = {5'b0, m_txo, m_rxo, (m_rx.size() != 0)};
         end else begin
            m_din = 8'h00;
         end
      end else if (rdy && wr) begin
         if (!io) m_ram[ra] = d;
         else if (a[15:0] == 16'h0000) begin
            if (m_tx.size() < 8) m_tx.push_back(d);
            else m_txo = 1'b1;
         end else if (a[15:0] == 16'h0004) m_halt = 1'b1;
      end
      if (rxv) begin
         if (m_rx.size() < 8) m_rx.push_back(rxd);
         else m_rxo = 1'b1;
      end
      @(posedge clk_in);
      #1;
      if (din_ok) chk("mem_din", mem_din, m_din);
      chk("io_buffer_full", io_buffer_full, (m_tx.size() >= 6));
      chk("uart_tx_valid", uart_tx_valid, (m_tx.size() != 0));
      if (m_tx.size() != 0) chk("uart_tx_data", uart_tx_data, m_tx[0]);
      chk("sim_halt", sim_halt, m_halt);
   endtask

   // Asserts reset between edges, holds it across one edge, releases on a falling edge.
   task automatic reset_chk();
      #2 rst_in = 1'b0;
      #1;
      chk("rst_mem_din", mem_din, 0);
      chk("rst_io_full", io_buffer_full, 0);
      chk("rst_tx_valid", uart_tx_valid, 0);
      chk("rst_sim_halt", sim_halt, 0);
      @(posedge clk_in);
      #1;
      chk("rst_hold_din", mem_din, 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      m_tx.delete(); m_rx.delete();
      m_txo = 1'b0; m_rxo = 1'b0; m_halt = 1'b0; m_din = 8'h00; din_ok = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      int sel;
      rst_in = 1'b1; rdy_in = 1'b0; mem_wr = 1'b0; mem_a = '0; mem_dout = '0;
      uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;

      tbl[0]  = '{1'b1, 1'b1, 32'h0000_0010, 8'hA5, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};
      tbl[2]  = '{1'b1, 1'b1, 32'h0000_0100, 8'h11, 8'hA5};
      tbl[3]  = '{1'b1, 1'b1, 32'h0000_0101, 8'h22, 8'hA5};
      tbl[4]  = '{1'b1, 1'b1, 32'h0000_0102, 8'h33, 8'hA5};
      tbl[5]  = '{1'b1, 1'b1, 32'h0000_0103, 8'h44, 8'hA5};
      tbl[6]  = '{1'b1, 1'b0, 32'h0000_0100, 8'h00, 8'h11};
      tbl[7]  = '{1'b1, 1'b0, 32'h0000_0101, 8'h00, 8'h22};
      tbl[8]  = '{1'b1, 1'b0, 32'h0000_0102, 8'h00, 8'h33};
      tbl[9]  = '{1'b1, 1'b0, 32'h0000_0103, 8'h00, 8'h44};
      tbl[10] = '{1'b0, 1'b0, 32'h0000_0100, 8'h00, 8'h44};
      tbl[11] = '{1'b1, 1'b0, 32'hFFFC_0101, 8'h00, 8'h22};
      tbl[12] = '{1'b1, 1'b0, 32'h0003_0008, 8'h00, 8'h00};
      tbl[13] = '{1'b1, 1'b1, 32'h0003_0008, 8'h77, 8'h00};
      tbl[14] = '{1'b0, 1'b1, 32'h0000_0010, 8'h5A, 8'h00};
      tbl[15] = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5};

      reset_chk();
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].rdy, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0, 1'b0, 8'h00);
         chk("tbl_din", mem_din, tbl[i].exp);
      end

      // TX fill with the drain stalled, overflow, then in-order drain with rdy_in low.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b1, 32'h0003_0000, 8'(8'h60 + i), 1'b0, 1'b0, 8'h00);
         if (i == 4) chk("full_after5", io_buffer_full, 0);
      end
      chk("full_after6", io_buffer_full, 1);
      for (int i = 6; i < 9; i++) cyc(1'b1, 1'b1, 32'h0003_0000, 8'(8'h60 + i), 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("status_tx_ovf", mem_din, 8'h04);
      for (int k = 0; k < 8; k++) begin
         chk("drain_valid", uart_tx_valid, 1);
         chk("drain_data", uart_tx_data, 8'h60 + k);
         cyc(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 8'h00);
      end
      chk("drain_empty", uart_tx_valid, 0);

      // RX fill past full with rdy_in low, then drain through UART reads.
      reset_chk();
      for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 8'(i));
      for (int i = 1; i <= 9; i++) begin
         cyc(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
         chk("rx_read", mem_din, (i <= 8) ? i : 0);
      end
      cyc(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("status_rx_overrun", mem_din[1], 1);
      chk("status_rx_nonempty", mem_din[0], 0);

      cyc(1'b0, 1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("halt_frozen", sim_halt, 0);
      cyc(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("halt_set", sim_halt, 1);

      // Reset with queued TX bytes and a read presented on the bus.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h0003_0000, 8'(8'hB0 + i), 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("pre_rst_din", mem_din, 8'hA5);
      rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0000_0100;
      reset_chk();
      cyc(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("post_rst_status", mem_din, 8'h00);

      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) a = ($urandom() & 32'hFFFC_0000) | 32'h0000_0200 | 32'($urandom_range(0, 15));
         else if (sel < 8) a = 32'h0003_0000;
         else if (sel == 8) a = 32'h0003_0004;
         else a = 32'h0003_000C;
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, a, 8'($urandom_range(0, 255)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
